// File: rtl/debug_ctrl_if.sv
// Bus bundle between the debug controller and its UART FIFOs / pipeline.
// master = controller side, slave = FIFO/pipeline side.
interface debug_ctrl_if #(
  parameter int unsigned INST_SZ = 32,
  parameter int unsigned PC_SZ   = 32,
  parameter int unsigned DATA_SZ = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MEM_W   = 5
);
  localparam int unsigned ADDR_W = (REG_W > MEM_W) ? REG_W : MEM_W;

  logic [7:0]         i_rx_data;
  logic               i_rx_empty;
  logic               o_rd;
  logic [7:0]         o_tx_data;
  logic               o_wr;
  logic               i_tx_full;
  logic [INST_SZ-1:0] o_instruction;
  logic               o_inst_wr;
  logic               o_enable;
  logic               o_soft_reset;
  logic [ADDR_W-1:0]  o_addr;
  logic [PC_SZ-1:0]   i_pc;
  logic [DATA_SZ-1:0] i_reg_data;
  logic [DATA_SZ-1:0] i_mem_data;
  logic               i_halt;

  modport master (
    input  i_rx_data, i_rx_empty, i_tx_full, i_pc, i_reg_data, i_mem_data, i_halt,
    output o_rd, o_tx_data, o_wr, o_instruction, o_inst_wr, o_enable, o_soft_reset, o_addr
  );

  modport slave (
    output i_rx_data, i_rx_empty, i_tx_full, i_pc, i_reg_data, i_mem_data, i_halt,
    input  o_rd, o_tx_data, o_wr, o_instruction, o_inst_wr, o_enable, o_soft_reset, o_addr
  );
endinterface

// File: rtl/debug_ctrl.sv
// UART-driven debug controller: decodes load/run/step/dump/soft-reset commands,
// counts executed cycles and serialises PC, cycle count, registers and memory.
module debug_ctrl #(
  parameter int unsigned INST_SZ = 32,
  parameter int unsigned PC_SZ   = 32,
  parameter int unsigned DATA_SZ = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MEM_W   = 5,
  parameter int unsigned CYC_SZ  = 32
) (
  input logic         i_clk,
  input logic         i_reset,
  debug_ctrl_if.master bus
);

  localparam int unsigned ADDR_W = (REG_W > MEM_W) ? REG_W : MEM_W;
  localparam int unsigned SH_A   = (PC_SZ > CYC_SZ) ? PC_SZ : CYC_SZ;
  localparam int unsigned SH_W   = (SH_A > DATA_SZ) ? SH_A : DATA_SZ;
  localparam int unsigned MAX_B  = ((INST_SZ > SH_W) ? INST_SZ : SH_W) / 8;
  localparam int unsigned BC_W   = $clog2(MAX_B + 1);

  localparam logic [BC_W-1:0]   INST_LAST = BC_W'(INST_SZ / 8 - 1);
  localparam logic [BC_W-1:0]   PC_LAST   = BC_W'(PC_SZ / 8 - 1);
  localparam logic [BC_W-1:0]   CYC_LAST  = BC_W'(CYC_SZ / 8 - 1);
  localparam logic [BC_W-1:0]   DATA_LAST = BC_W'(DATA_SZ / 8 - 1);
  localparam logic [ADDR_W-1:0] REG_LAST  = ADDR_W'((1 << REG_W) - 1);
  localparam logic [ADDR_W-1:0] MEM_LAST  = ADDR_W'((1 << MEM_W) - 1);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_SRST = 8'h58;
  localparam logic [7:0] ACK_BYTE = 8'h4B;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CNT, S_LOAD_BYTE, S_LOAD_WR, S_RUN, S_STEP, S_SRST,
    S_SEND, S_DUMP_PC, S_DUMP_TX, S_DUMP_ADDR, S_DUMP_LATCH
  } state_t;

  typedef enum logic [1:0] {SEC_PC, SEC_CYC, SEC_REG, SEC_MEM} sec_t;

  state_t             state;
  sec_t               sec;
  logic [SH_W-1:0]    sh;
  logic [BC_W-1:0]    byte_cnt;
  logic [BC_W-1:0]    word_last;
  logic [INST_SZ-1:0] inst_sh;
  logic [7:0]         inst_left;
  logic               step_en;
  logic [CYC_SZ-1:0]  cyc;
  logic [7:0]         tx_byte;

  // A strobe still in flight blocks the next one, so FIFO flags are never stale.
  logic rx_ok, tx_ok;
  assign rx_ok = !bus.i_rx_empty && !bus.o_rd;
  assign tx_ok = !bus.i_tx_full && !bus.o_wr;

  // Enable must drop in the very cycle halt rises, hence combinational on i_halt.
  assign bus.o_enable = i_reset &&
                        (((state == S_RUN) && !bus.i_halt) || ((state == S_STEP) && step_en));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state             <= S_IDLE;
      sec               <= SEC_PC;
      sh                <= '0;
      byte_cnt          <= '0;
      word_last         <= '0;
      inst_sh           <= '0;
      inst_left         <= '0;
      step_en           <= 1'b0;
      cyc               <= '0;
      tx_byte           <= '0;
      bus.o_rd          <= 1'b0;
      bus.o_wr          <= 1'b0;
      bus.o_tx_data     <= '0;
      bus.o_instruction <= '0;
      bus.o_inst_wr     <= 1'b0;
      bus.o_soft_reset  <= 1'b0;
      bus.o_addr        <= '0;
    end else begin
      bus.o_rd         <= 1'b0;
      bus.o_wr         <= 1'b0;
      bus.o_inst_wr    <= 1'b0;
      bus.o_soft_reset <= 1'b0;
      case (state)
        S_IDLE: if (rx_ok) begin
          bus.o_rd <= 1'b1;
          case (bus.i_rx_data)
            CMD_LOAD: state <= S_LOAD_CNT;
            CMD_RUN:  state <= S_RUN;
            CMD_STEP: begin
              step_en <= !bus.i_halt;
              state   <= S_STEP;
            end
            CMD_DUMP: state <= S_DUMP_PC;
            CMD_SRST: state <= S_SRST;
            default: begin
              tx_byte <= ERR_BYTE;
              state   <= S_SEND;
            end
          endcase
        end
        S_LOAD_CNT: if (rx_ok) begin
          bus.o_rd  <= 1'b1;
          inst_left <= bus.i_rx_data;
          byte_cnt  <= '0;
          if (bus.i_rx_data == 8'd0) begin
            tx_byte <= ACK_BYTE;
            state   <= S_SEND;
          end else begin
            state <= S_LOAD_BYTE;
          end
        end
        S_LOAD_BYTE: if (rx_ok) begin
          bus.o_rd <= 1'b1;
          inst_sh  <= INST_SZ'({bus.i_rx_data, inst_sh} >> 8);
          byte_cnt <= byte_cnt + BC_W'(1);
          if (byte_cnt == INST_LAST) begin
            byte_cnt <= '0;
            state    <= S_LOAD_WR;
          end
        end
        S_LOAD_WR: begin
          bus.o_instruction <= inst_sh;
          bus.o_inst_wr     <= 1'b1;
          inst_left         <= inst_left - 8'd1;
          if (inst_left == 8'd1) begin
            tx_byte <= ACK_BYTE;
            state   <= S_SEND;
          end else begin
            state <= S_LOAD_BYTE;
          end
        end
        S_RUN: begin
          if (bus.i_halt) state <= S_DUMP_PC;
          else            cyc   <= cyc + CYC_SZ'(1);
        end
        S_STEP: begin
          if (step_en) cyc <= cyc + CYC_SZ'(1);
          state <= S_DUMP_PC;
        end
        S_SRST: begin
          bus.o_soft_reset <= 1'b1;
          cyc              <= '0;
          tx_byte          <= ACK_BYTE;
          state            <= S_SEND;
        end
        S_SEND: if (tx_ok) begin
          bus.o_wr      <= 1'b1;
          bus.o_tx_data <= tx_byte;
          state         <= S_IDLE;
        end
        S_DUMP_PC: begin
          sh        <= SH_W'(bus.i_pc);
          word_last <= PC_LAST;
          byte_cnt  <= '0;
          sec       <= SEC_PC;
          state     <= S_DUMP_TX;
        end
        S_DUMP_TX: if (tx_ok) begin
          bus.o_wr      <= 1'b1;
          bus.o_tx_data <= sh[7:0];
          sh            <= sh >> 8;
          byte_cnt      <= byte_cnt + BC_W'(1);
          if (byte_cnt == word_last) begin
            byte_cnt <= '0;
            case (sec)
              SEC_PC: begin
                sh        <= SH_W'(cyc);
                word_last <= CYC_LAST;
                sec       <= SEC_CYC;
              end
              SEC_CYC: begin
                sec        <= SEC_REG;
                bus.o_addr <= '0;
                state      <= S_DUMP_ADDR;
              end
              SEC_REG: begin
                if (bus.o_addr == REG_LAST) begin
                  sec        <= SEC_MEM;
                  bus.o_addr <= '0;
                end else begin
                  bus.o_addr <= bus.o_addr + ADDR_W'(1);
                end
                state <= S_DUMP_ADDR;
              end
              default: begin
                if (bus.o_addr == MEM_LAST) begin
                  state <= S_IDLE;
                end else begin
                  bus.o_addr <= bus.o_addr + ADDR_W'(1);
                  state      <= S_DUMP_ADDR;
                end
              end
            endcase
          end
        end
        // Address was driven last cycle; read data becomes valid in S_DUMP_LATCH.
        S_DUMP_ADDR: state <= S_DUMP_LATCH;
        S_DUMP_LATCH: begin
          sh        <= (sec == SEC_MEM) ? SH_W'(bus.i_mem_data) : SH_W'(bus.i_reg_data);
          word_last <= DATA_LAST;
          byte_cnt  <= '0;
          state     <= S_DUMP_TX;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ctrl.sv
// Self-checking bench for debug_ctrl: FIFO/pipeline models plus a byte-stream
// reference model of every command response.
module tb_debug_ctrl;
  localparam logic [7:0] ACK  = 8'h4B;
  localparam logic [7:0] ERR  = 8'hEE;
  localparam int         HUGE = 32'h7fff_ffff;
  localparam int         DUMP_LEN = 4 + 4 + 4 * 32 + 4 * 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_ctrl_if bus ();
  debug_ctrl dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  logic [7:0]  rx_mem [0:1023];
  int          rx_wp = 0;
  int          rx_rp = 0;
  int          rd_err = 0;
  logic [7:0]  txq[$];
  logic [7:0]  exp_q[$];
  logic [31:0] instq[$];
  logic [31:0] exp_inst[$];
  logic [31:0] regs [0:31];
  logic [31:0] mems [0:31];
  int          en_total = 0;
  int          srst_cnt = 0;
  int          bp_err = 0;
  int          halt_target = HUGE;
  bit          full_force = 1'b0;
  bit          bp_rand = 1'b0;
  logic        full_prev = 1'b0;
  logic [31:0] model_cyc = '0;

  // First-word-fall-through RX FIFO
  assign bus.i_rx_empty = (rx_wp == rx_rp);
  assign bus.i_rx_data  = rx_mem[rx_rp % 1024];

  // TX sink, instruction sink, pipeline and register/memory read models
  always @(posedge clk) begin
    if (bus.o_rd) begin
      if (rx_wp == rx_rp) rd_err++;
      else rx_rp++;
    end
    if (bus.o_wr) begin
      txq.push_back(bus.o_tx_data);
      if (full_prev === 1'b1) bp_err++;
    end
    full_prev = bus.i_tx_full;
    if (bus.o_inst_wr) instq.push_back(bus.o_instruction);
    if (bus.o_enable) en_total++;
    if (bus.o_soft_reset) srst_cnt++;
    bus.i_reg_data <= regs[bus.o_addr];
    bus.i_mem_data <= mems[bus.o_addr];
  end

  always @(negedge clk) begin
    bus.i_halt    = (en_total >= halt_target);
    bus.i_tx_full = full_force || (bp_rand && ($urandom_range(0, 2) == 0));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_mem[rx_wp % 1024] = b;
    rx_wp++;
  endtask

  task automatic set_halt(input int t);
    halt_target = t;
    tick(2);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int b = 0;
    while (txq.size() < n && b < 20000) begin
      @(negedge clk);
      b++;
    end
    ok = (txq.size() >= n);
    tick(8);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 32; k++) begin
      regs[k] = $urandom;
      mems[k] = $urandom;
    end
  endtask

  function automatic void exp_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endfunction

  function automatic void exp_dump(input logic [31:0] pc, input logic [31:0] cyc);
    exp_word(pc);
    exp_word(cyc);
    for (int k = 0; k < 32; k++) exp_word(regs[k]);
    for (int k = 0; k < 32; k++) exp_word(mems[k]);
  endfunction

  function automatic int diff_count();
    int d = (txq.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < txq.size() && i < exp_q.size(); i++)
      if (txq[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic clear_q();
    txq.delete();
    exp_q.delete();
    instq.delete();
    exp_inst.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total++;
    if ({bus.o_rd, bus.o_wr, bus.o_inst_wr, bus.o_enable, bus.o_soft_reset} !== 5'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 00000",
               {bus.o_rd, bus.o_wr, bus.o_inst_wr, bus.o_enable, bus.o_soft_reset});
    end
    total++;
    if ({bus.o_tx_data, bus.o_instruction} !== 40'h0) begin
      bad++;
      $display("FAIL reset_data: tx=%h inst=%h want 0", bus.o_tx_data, bus.o_instruction);
    end
    total++;
    if (bus.o_addr !== 5'd0) begin
      bad++;
      $display("FAIL reset_addr: got %0d want 0", bus.o_addr);
    end
    rst_n = 1'b1;
    model_cyc = '0;
    tick(2);
    clear_q();
  endtask

  task automatic test_load();
    bit ok;
    logic [7:0] lb [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_q();
    send(8'h4C);
    send(8'h02);
    for (int i = 0; i < 8; i++) send(lb[i]);
    wait_tx(1, ok);
    total++;
    if (txq.size() != 1 || txq[0] !== ACK) begin
      bad++;
      $display("FAIL load_ack: got %0d bytes first=%h want 1 byte 4b", txq.size(),
               (txq.size() > 0) ? txq[0] : 8'h00);
    end
    total++;
    if (instq.size() != 2 || instq[0] !== 32'h12345678 || instq[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL load_inst: got %0d writes want 2 (12345678, deadbeef)", instq.size());
    end
    total++;
    if (bus.o_instruction !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL load_hold: got %h want deadbeef", bus.o_instruction);
    end
    clear_q();
    send(8'h4C);
    send(8'h00);
    wait_tx(1, ok);
    total++;
    if (txq.size() != 1 || txq[0] !== ACK || instq.size() != 0) begin
      bad++;
      $display("FAIL load_zero: got %0d bytes %0d writes want 1 byte 0 writes",
               txq.size(), instq.size());
    end
  endtask

  task automatic test_run();
    bit ok;
    int e0;
    clear_q();
    fill_rand();
    bus.i_pc = 32'h1C;
    set_halt(en_total + 7);
    e0 = en_total;
    send(8'h52);
    send(8'h44);
    wait_tx(2 * DUMP_LEN, ok);
    model_cyc = model_cyc + 32'd7;
    exp_dump(32'h1C, model_cyc);
    exp_dump(32'h1C, model_cyc);
    total++;
    if (en_total - e0 != 7) begin
      bad++;
      $display("FAIL run_enables: got %0d want 7", en_total - e0);
    end
    total++;
    if (txq.size() < 8 || {txq[7], txq[6], txq[5], txq[4], txq[3], txq[2], txq[1], txq[0]}
        !== 64'h00000007_0000001C) begin
      bad++;
      $display("FAIL run_header: got %0d bytes, want 1c 00 00 00 07 00 00 00", txq.size());
    end
    total++;
    if (diff_count() != 0) begin
      bad++;
      $display("FAIL run_dump: %0d diffs, got %0d bytes want %0d", diff_count(),
               txq.size(), exp_q.size());
    end
    set_halt(HUGE);
  endtask

  task automatic test_soft_reset();
    bit ok;
    int n, s0;
    clear_q();
    n = $urandom_range(1, 20);
    bus.i_pc = $urandom;
    set_halt(en_total + n);
    s0 = srst_cnt;
    send(8'h52);
    send(8'h58);
    send(8'h44);
    wait_tx(2 * DUMP_LEN + 1, ok);
    exp_dump(bus.i_pc, model_cyc + 32'(n));
    exp_q.push_back(ACK);
    model_cyc = '0;
    exp_dump(bus.i_pc, model_cyc);
    total++;
    if (srst_cnt - s0 != 1) begin
      bad++;
      $display("FAIL srst_pulse: got %0d cycles want 1", srst_cnt - s0);
    end
    total++;
    if (diff_count() != 0) begin
      bad++;
      $display("FAIL srst_stream: %0d diffs, got %0d bytes want %0d", diff_count(),
               txq.size(), exp_q.size());
    end
    set_halt(HUGE);
  endtask

  task automatic test_step();
    bit ok;
    int e0;
    clear_q();
    for (int k = 0; k < 32; k++) begin
      regs[k] = 32'(k * 3);
      mems[k] = $urandom;
    end
    bus.i_pc = $urandom;
    e0 = en_total;
    send(8'h53);
    send(8'h53);
    send(8'h44);
    wait_tx(3 * DUMP_LEN, ok);
    exp_dump(bus.i_pc, model_cyc + 32'd1);
    exp_dump(bus.i_pc, model_cyc + 32'd2);
    exp_dump(bus.i_pc, model_cyc + 32'd2);
    model_cyc = model_cyc + 32'd2;
    total++;
    if (en_total - e0 != 2) begin
      bad++;
      $display("FAIL step_enables: got %0d want 2", en_total - e0);
    end
    total++;
    if (diff_count() != 0) begin
      bad++;
      $display("FAIL step_dump: %0d diffs, got %0d bytes want %0d", diff_count(),
               txq.size(), exp_q.size());
    end
  endtask

  task automatic test_halt_on_entry();
    bit ok;
    int e0;
    clear_q();
    fill_rand();
    set_halt(0);
    e0 = en_total;
    send(8'h53);
    send(8'h52);
    wait_tx(2 * DUMP_LEN, ok);
    exp_dump(bus.i_pc, model_cyc);
    exp_dump(bus.i_pc, model_cyc);
    total++;
    if (en_total - e0 != 0) begin
      bad++;
      $display("FAIL halted_enables: got %0d want 0", en_total - e0);
    end
    total++;
    if (diff_count() != 0) begin
      bad++;
      $display("FAIL halted_dump: %0d diffs, got %0d bytes want %0d", diff_count(),
               txq.size(), exp_q.size());
    end
    set_halt(HUGE);
  endtask

  task automatic test_backpressure();
    bit ok;
    int b = 0;
    clear_q();
    fill_rand();
    bus.i_pc = $urandom;
    bp_err = 0;
    send(8'h44);
    while (txq.size() < 30 && b < 5000) begin
      @(negedge clk);
      b++;
    end
    full_force = 1'b1;
    tick(10);
    full_force = 1'b0;
    bp_rand = 1'b1;
    send(8'h41);
    wait_tx(DUMP_LEN + 1, ok);
    bp_rand = 1'b0;
    exp_dump(bus.i_pc, model_cyc);
    exp_q.push_back(ERR);
    total++;
    if (diff_count() != 0) begin
      bad++;
      $display("FAIL bp_stream: %0d diffs, got %0d bytes want %0d", diff_count(),
               txq.size(), exp_q.size());
    end
    total++;
    if (bp_err != 0) begin
      bad++;
      $display("FAIL bp_full_write: got %0d writes while full want 0", bp_err);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    int b = 0;
    clear_q();
    bus.i_pc = 32'h0;
    send(8'h44);
    while (txq.size() < 40 && b < 5000) begin
      @(negedge clk);
      b++;
    end
    rst_n = 1'b0;
    tick(2);
    total++;
    if ({bus.o_rd, bus.o_wr, bus.o_inst_wr, bus.o_enable, bus.o_soft_reset, bus.o_addr,
         bus.o_tx_data} !== 18'h0) begin
      bad++;
      $display("FAIL midreset_outputs: wr=%b addr=%0d tx=%h want 0", bus.o_wr, bus.o_addr,
               bus.o_tx_data);
    end
    rst_n = 1'b1;
    model_cyc = '0;
    tick(2);
    clear_q();
    send(8'h44);
    wait_tx(DUMP_LEN, ok);
    exp_dump(32'h0, model_cyc);
    total++;
    if (diff_count() != 0) begin
      bad++;
      $display("FAIL midreset_dump: %0d diffs, got %0d bytes want %0d", diff_count(),
               txq.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    int op, n, e0, s0, want_en;
    logic [7:0]  v;
    logic [31:0] w;
    for (int it = 0; it < 12; it++) begin
      clear_q();
      fill_rand();
      bus.i_pc = $urandom;
      op = $urandom_range(0, 5);
      e0 = en_total;
      s0 = srst_cnt;
      want_en = 0;
      case (op)
        0: begin
          n = $urandom_range(0, 4);
          send(8'h4C);
          send(8'(n));
          for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_inst.push_back(w);
            for (int b = 0; b < 4; b++) send(w[8*b +: 8]);
          end
          exp_q.push_back(ACK);
        end
        1: begin
          n = $urandom_range(0, 1);
          set_halt(n != 0 ? 0 : HUGE);
          e0 = en_total;
          want_en = (n != 0) ? 0 : 1;
          model_cyc = model_cyc + 32'(want_en);
          send(8'h53);
          exp_dump(bus.i_pc, model_cyc);
        end
        2: begin
          n = $urandom_range(0, 10);
          set_halt(en_total + n);
          e0 = en_total;
          want_en = n;
          model_cyc = model_cyc + 32'(n);
          send(8'h52);
          exp_dump(bus.i_pc, model_cyc);
        end
        3: begin
          send(8'h44);
          exp_dump(bus.i_pc, model_cyc);
        end
        4: begin
          send(8'h58);
          model_cyc = '0;
          exp_q.push_back(ACK);
        end
        default: begin
          v = 8'($urandom_range(0, 255));
          while (v == 8'h4C || v == 8'h52 || v == 8'h53 || v == 8'h44 || v == 8'h58)
            v = 8'($urandom_range(0, 255));
          send(v);
          exp_q.push_back(ERR);
        end
      endcase
      wait_tx(exp_q.size(), ok);
      total++;
      if (diff_count() != 0 || instq != exp_inst) begin
        bad++;
        $display("FAIL rand_op%0d_it%0d: %0d diffs, got %0d bytes %0d writes want %0d bytes %0d writes",
                 op, it, diff_count(), txq.size(), instq.size(), exp_q.size(), exp_inst.size());
      end
      total++;
      if (en_total - e0 != want_en || srst_cnt - s0 != ((op == 4) ? 1 : 0)) begin
        bad++;
        $display("FAIL rand_side_it%0d: enables=%0d srst=%0d want %0d/%0d", it,
                 en_total - e0, srst_cnt - s0, want_en, (op == 4) ? 1 : 0);
      end
      set_halt(HUGE);
    end
    total++;
    if (rx_rp != rx_wp || rd_err != 0) begin
      bad++;
      $display("FAIL rx_drain: read %0d of %0d bytes, %0d pops on empty want all read 0 bad",
               rx_rp, rx_wp, rd_err);
    end
  endtask

  initial begin
    bus.i_pc = '0;
    for (int k = 0; k < 32; k++) begin
      regs[k] = '0;
      mems[k] = '0;
    end
    test_reset();
    test_load();
    test_run();
    test_soft_reset();
    test_step();
    test_halt_on_entry();
    test_backpressure();
    test_reset_mid_dump();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
